serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built around a single 1-bit full-adder datapath
//  (Sum = A^B^Cin, Cout = majority(A,B,Cin)) and a carry flip-flop.
//  - Loads two operands plus carry-in on a start request.
//  - Adds one bit per clock, LSB first.
//  - Presents the WIDTH-bit sum and final carry-out with a one-cycle done pulse.
//  - Is the sequential stage that feeds the full-adder cell. Used where area

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 91 +++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Request/result bundle between a serial_adder and whoever drives it.
// The master supplies operands and start; the slave returns status and result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, one bit per clock,
// LSB first; the result is registered and flagged with a one-cycle done pulse.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa, opb, acc, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry, cout_q, busy_q, done_q;
    logic             s, co;

    serial_adder_fa u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa    <= bus.A;
                        opb    <= bus.B;
                        carry  <= bus.Cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    carry <= co;
                    acc   <= {s, acc[WIDTH-1:1]};
                    opa   <= {1'b0, opa[WIDTH-1:1]};
                    opb   <= {1'b0, opb[WIDTH-1:1]};
                    // Last bit: publish straight from the cell outputs so the
                    // result lands on the same edge as the final shift.
                    if (cnt == LAST) begin
                        sum_q  <= {s, acc[WIDTH-1:1]};
                        cout_q <= co;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder: scoreboard of expected
// {Cout,Sum}, popped by a monitor on every done pulse.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W:0] sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_done = 0;
    int         n_push = 0;
    logic [W:0] last_res;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                chk("result", 32'({bus.Cout, bus.Sum}), 32'(sb.pop_front()));
            end
        end
    end

    // Drive a start; the accepting edge is the next posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input bit push);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = ci;
        if (push) begin
            sb.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(ci));
            n_push++;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.Cin   = ~ci;
    endtask

    // Follow one operation from just after its accept edge to its done cycle.
    task automatic wait_done(input logic [W:0] held, input int poke);
        int bc = 0;
        int early = 0;
        int hold_bad = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            bc += int'(bus.busy);
            early += int'(bus.done);
            if ({bus.Cout, bus.Sum} !== held) hold_bad++;
            if (i == poke) begin
                bus.start = 1'b1;
                bus.A     = 8'h33;
                bus.B     = 8'h44;
                bus.Cin   = 1'b1;
            end else if (i == poke + 1) begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        chk("busy_cycles", 32'(bc), 32'(W));
        chk("early_done", 32'(early), 32'd0);
        chk("sum_held", 32'(hold_bad), 32'd0);
        chk("done_latency", 32'(bus.done), 32'd1);
        chk("busy_after", 32'(bus.busy), 32'd0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        issue(a, b, ci, 1'b1);
        wait_done(last_res, -10);
        last_res = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
    endtask

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'({bus.Cout, bus.Sum}), 32'd0);
        rst = 1'b0;
        last_res = '0;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        op(8'h00, 8'h00, 1'b0);
        chk("zero_case", 32'({bus.Cout, bus.Sum}), 32'h000);
        @(negedge clk);
        op(8'hFF, 8'h01, 1'b0);
        chk("full_ripple", 32'({bus.Cout, bus.Sum}), 32'h100);
        @(negedge clk);
        op(8'hA5, 8'h5A, 1'b1);
        chk("cin_ripple", 32'({bus.Cout, bus.Sum}), 32'h100);
        @(negedge clk);
        op(8'd100, 8'd27, 1'b1);
        chk("cin_100_27", 32'({bus.Cout, bus.Sum}), 32'h080);
        @(negedge clk);

        // Start while busy is ignored: only one done, no second operation.
        d0 = n_done;
        issue(8'h12, 8'h34, 1'b0, 1'b1);
        wait_done(last_res, 2);
        last_res = 9'h046;
        chk("busy_start_sum", 32'({bus.Cout, bus.Sum}), 32'h046);
        @(negedge clk);
        chk("busy_start_idle", 32'(bus.busy), 32'd0);
        chk("busy_start_pulse", 32'(n_done - d0), 32'd1);

        // Reset in the middle of an addition: cleared, no done follows.
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum", 32'({bus.Cout, bus.Sum}), 32'd0);
        d0 = n_done;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        last_res = '0;

        // Back-to-back: start held during the done cycle.
        op(8'h0F, 8'hF0, 1'b0);
        issue(8'h80, 8'h80, 1'b1, 1'b1);
        wait_done(9'h0FF, -10);
        chk("b2b_second", 32'({bus.Cout, bus.Sum}), 32'h101);
        last_res = 9'h101;
        @(negedge clk);

        // Random sweep against A+B+Cin via the scoreboard.
        for (int i = 0; i < 256; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom));
        end

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(n_done), 32'(n_push));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
